mppt_po_scheduler: RTL and testbench
====================================

Name: mppt_po_scheduler

Overview:
- Perturb-and-observe maximum-power-point tracking (MPPT) controller for the renewable converter datapath.
- Sequences the converter duty command: change duty, wait for the power stage to settle, average power samples from the 8-bit ADC path, compare against the previous average, then choose the next perturbation direction.
- Sits between the sample front-end (ui_in-derived V/I samples) and the PWM generator that drives the converter.

Parameters:
- DUTY_INIT, 128, duty value loaded at reset.
- DUTY_MIN, 16, lowest legal duty.
- DUTY_MAX, 240, highest legal duty.
- STEP, 4, duty increment per perturbation.
- SETTLE_CYCLES, 8, clock cycles waited after each duty change, range 1..255.
- AVG_LOG2, 2, log2 of samples averaged per observation, range 0..4.
- DEADBAND, 16, power hysteresis; used only with MPPT_DEADBAND_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  tracking enable.
- sample_valid  in  1  v_sample/i_sample are valid this cycle.
- v_sample  in  8  unsigned voltage code.
- i_sample  in  8  unsigned current code.
- duty  out  8  duty command to the PWM stage.
- duty_update  out  1  one-cycle pulse when duty changes.
- dir_up  out  1  current perturbation direction; 1 = increase.
- power_avg  out  16  last completed power average.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: duty=DUTY_INIT, dir_up=1, duty_update=0, power_avg=0, busy=0, prev_power=0, have_prev=0, state IDLE, all counters 0.
- Reset overrides everything, including mid-ACQUIRE; any partial accumulation is discarded.
- Power per sample: p = v_sample*i_sample, 16-bit unsigned.
- Accumulator: 16+AVG_LOG2 bits. Average = acc >> AVG_LOG2 (truncating).
- IDLE:
  - Outputs held.
  - enable=1 -> SETTLE, settle counter cleared.
- SETTLE:
  - Counts SETTLE_CYCLES clocks; sample_valid is ignored.
  - On terminal count -> ACQUIRE, accumulator and sample count cleared.
- ACQUIRE:
  - Each cycle with sample_valid=1 adds p and increments the count.
  - When the count reaches 2^AVG_LOG2 (the accepting edge) -> COMPARE.
  - Gaps in sample_valid simply stall the state.
- COMPARE (1 cycle):
  - power_avg <= average.
  - If have_prev=1 and average < prev_power: toggle dir_up.
  - If average >= prev_power, or have_prev=0: keep dir_up.
  - prev_power <= average; have_prev <= 1.
  - -> PERTURB.
- PERTURB (1 cycle):
  - candidate = duty ± STEP according to dir_up (evaluated after the COMPARE update), computed at 9 bits.
  - Candidate above DUTY_MAX: duty <= DUTY_MAX, dir_up <= 0.
  - Candidate below DUTY_MIN: duty <= DUTY_MIN, dir_up <= 1.
  - duty_update pulses for one cycle only if the duty value actually changed.
  - -> SETTLE.
- Latency: duty and duty_update register on the 2nd rising edge after the edge accepting the final sample.
- enable deasserted in SETTLE or ACQUIRE: next edge -> IDLE; accumulator dropped; duty, dir_up, prev_power and have_prev retained.
- enable deasserted in COMPARE or PERTURB: the current state completes, then -> IDLE.
- Re-enable from IDLE: SETTLE begins; have_prev is kept.
- Boundary: duty already at DUTY_MAX with dir_up=1 -> duty unchanged, no duty_update pulse, dir_up flips to 0.

Optional Feature:
- Macro MPPT_DEADBAND_EN.
- Defined: in COMPARE, if have_prev=1 and |average - prev_power| <= DEADBAND:
  - the step is treated as converged;
  - dir_up is unchanged, prev_power is not updated;
  - PERTURB leaves duty unchanged, no duty_update pulse;
  - the controller still returns to SETTLE.
- Undefined: DEADBAND is unused; behaviour is exactly as above.

Test Plan:
- Reset check: rst high 3 cycles -> duty=128, dir_up=1, busy=0, power_avg=0, duty_update=0.
- First perturbation: enable=1, constant v=100, i=50, sample_valid every cycle -> power_avg=5000, duty 128->132 with one duty_update pulse. Next iteration (equal power) -> 136, dir_up stays 1.
- Power drop: after duty=136, drive v=80, i=50 -> power_avg=4000, dir_up toggles to 0, duty 136->132.
- Upper clamp: DUTY_INIT=238, rising power -> duty clamps to 240, dir_up=0. Next iteration without an intervening drop -> 236.
- Sparse samples and reset mid-ACQUIRE: sample_valid every 3rd cycle -> settle timing unchanged, averages correct. Assert rst after 2 of 4 samples -> all reset values restored, no duty_update.
- Deadband (MPPT_DEADBAND_EN): prev=5000, new v=101, i=50 (5050, difference 50 > 16) -> step taken. Then v=100, i=50 (5000 vs 5050, difference 50) -> step taken. Then 5008 vs 5000 (difference 8) -> duty held, no duty_update pulse.

Source files
------------

// File: rtl/mppt_po_scheduler.sv
// Perturb-and-observe MPPT duty scheduler: settle, average power, compare, step duty.
// Optional power deadband convergence enabled by defining MPPT_DEADBAND_EN.
module mppt_po_scheduler #(
    parameter int unsigned DUTY_INIT     = 128,
    parameter int unsigned DUTY_MIN      = 16,
    parameter int unsigned DUTY_MAX      = 240,
    parameter int unsigned STEP          = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned DEADBAND      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [7:0]  v_sample,
    input  logic [7:0]  i_sample,
    output logic [7:0]  duty,
    output logic        duty_update,
    output logic        dir_up,
    output logic [15:0] power_avg,
    output logic        busy
);

    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int NSAMP = 1 << AVG_LOG2;

    typedef enum logic [2:0] {IDLE, SETTLE, ACQUIRE, COMPARE, PERTURB} state_t;

    state_t           state_q, state_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [4:0]       samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       duty_q, duty_d;
    logic             dir_q, dir_d;
    logic             upd_q, upd_d;
    logic [15:0]      power_avg_q, power_avg_d;
    logic [15:0]      prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             hold_q, hold_d;

    logic [15:0] sample_power;
    logic [15:0] average;
    logic [8:0]  cand;
    logic        converged;
    logic [7:0]  new_duty;

    assign sample_power = 16'(v_sample) * 16'(i_sample);
    assign average      = 16'(acc_q >> AVG_LOG2);
    // Candidate kept at 9 bits so an overshoot past DUTY_MAX is visible before clamping.
    assign cand = dir_q ? ({1'b0, duty_q} + 9'(STEP)) : ({1'b0, duty_q} - 9'(STEP));

`ifdef MPPT_DEADBAND_EN
    logic [15:0] avg_diff;
    assign avg_diff = (average >= prev_q) ? (average - prev_q) : (prev_q - average);
`else
    logic [15:0] unused_deadband;
    assign unused_deadband = 16'(DEADBAND);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            acc_q        <= '0;
            duty_q       <= 8'(DUTY_INIT);
            dir_q        <= 1'b1;
            upd_q        <= 1'b0;
            power_avg_q  <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            acc_q        <= acc_d;
            duty_q       <= duty_d;
            dir_q        <= dir_d;
            upd_q        <= upd_d;
            power_avg_q  <= power_avg_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        acc_d        = acc_q;
        duty_d       = duty_q;
        dir_d        = dir_q;
        upd_d        = 1'b0;
        power_avg_d  = power_avg_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        hold_d       = hold_q;
        converged    = 1'b0;
        new_duty     = duty_q;
`ifdef MPPT_DEADBAND_EN
        converged    = have_prev_q && (avg_diff <= 16'(DEADBAND));
`endif

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    samp_cnt_d = '0;
                end else if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d    = ACQUIRE;
                    acc_d      = '0;
                    samp_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ACQUIRE: begin
                if (!enable) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    samp_cnt_d = '0;
                end else if (sample_valid) begin
                    acc_d      = acc_q + ACC_W'(sample_power);
                    samp_cnt_d = samp_cnt_q + 5'd1;
                    if (samp_cnt_q == 5'(NSAMP - 1)) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                power_avg_d = average;
                hold_d      = converged;
                if (!converged) begin
                    if (have_prev_q && (average < prev_q)) begin
                        dir_d = ~dir_q;
                    end
                    prev_d      = average;
                    have_prev_d = 1'b1;
                end
                state_d = PERTURB;
            end
            PERTURB: begin
                if (!hold_q) begin
                    if (cand > 9'(DUTY_MAX)) begin
                        new_duty = 8'(DUTY_MAX);
                        dir_d    = 1'b0;
                    end else if (cand < 9'(DUTY_MIN)) begin
                        new_duty = 8'(DUTY_MIN);
                        dir_d    = 1'b1;
                    end else begin
                        new_duty = cand[7:0];
                    end
                end
                duty_d       = new_duty;
                upd_d        = (new_duty != duty_q);
                settle_cnt_d = '0;
                state_d      = enable ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign duty        = duty_q;
    assign duty_update = upd_q;
    assign dir_up      = dir_q;
    assign power_avg   = power_avg_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mppt_po_scheduler.sv
// Directed self-checking bench for mppt_po_scheduler (default DUT plus a DUTY_INIT=238 clamp DUT).
module tb_mppt_po_scheduler;

`ifdef MPPT_DEADBAND_EN
    localparam bit deadbandOn = 1'b1;
`else
    localparam bit deadbandOn = 1'b0;
`endif
    // Equal-power iterations are held under the deadband, shifting later duty values by one step.
    localparam int dbOff = deadbandOn ? 4 : 0;

    logic        clk = 1'b0;
    logic        rst, rst2, enable, enable2, sampleValid;
    logic [7:0]  vSample, iSample;
    logic [7:0]  duty, duty2;
    logic        dutyUpdate, dutyUpdate2, dirUp, dirUp2, busy, busy2;
    logic [15:0] powerAvg, powerAvg2;
    int          checks = 0;
    int          failures = 0;
    int          pulses;

    always #5 clk = ~clk;

    mppt_po_scheduler dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sampleValid),
        .v_sample(vSample), .i_sample(iSample), .duty(duty), .duty_update(dutyUpdate),
        .dir_up(dirUp), .power_avg(powerAvg), .busy(busy)
    );

    mppt_po_scheduler #(.DUTY_INIT(238)) dutClamp (
        .clk(clk), .rst(rst2), .enable(enable2), .sample_valid(sampleValid),
        .v_sample(vSample), .i_sample(iSample), .duty(duty2), .duty_update(dutyUpdate2),
        .dir_up(dirUp2), .power_avg(powerAvg2), .busy(busy2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Runs nEdges clocks; odd-numbered edges see sample A, even ones sample B.
    task automatic applyStimulus(input int nEdges, input bit sparse,
                                 input logic [7:0] vA, input logic [7:0] iA,
                                 input logic [7:0] vB, input logic [7:0] iB,
                                 input bit useClamp, output int nPulses);
        nPulses = 0;
        for (int k = 1; k <= nEdges; k++) begin
            sampleValid = sparse ? ((k % 3) == 0) : 1'b1;
            vSample     = (k % 2 == 1) ? vA : vB;
            iSample     = (k % 2 == 1) ? iA : iB;
            @(posedge clk);
            @(negedge clk);
            if (useClamp ? dutyUpdate2 : dutyUpdate) nPulses++;
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; enable = 1'b0; enable2 = 1'b0;
        sampleValid = 1'b0; vSample = 8'd0; iSample = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_duty", duty, 128);
        checkOutput("rst_dir", dirUp, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pavg", powerAvg, 0);
        checkOutput("rst_upd", dutyUpdate, 0);
        checkOutput("rst_duty_clampdut", duty2, 238);

        rst = 1'b0; rst2 = 1'b0; enable = 1'b1;
        applyStimulus(15, 0, 100, 50, 100, 50, 0, pulses);
        checkOutput("it1_pavg", powerAvg, 5000);
        checkOutput("it1_duty", duty, 132);
        checkOutput("it1_dir", dirUp, 1);
        checkOutput("it1_pulses", pulses, 1);
        checkOutput("it1_busy", busy, 1);

        applyStimulus(14, 0, 100, 50, 100, 50, 0, pulses);
        checkOutput("it2_equal_duty", duty, 136 - dbOff);
        checkOutput("it2_equal_dir", dirUp, 1);
        checkOutput("it2_equal_pulses", pulses, deadbandOn ? 0 : 1);

        applyStimulus(14, 0, 80, 50, 80, 50, 0, pulses);
        checkOutput("it3_drop_pavg", powerAvg, 4000);
        checkOutput("it3_drop_dir", dirUp, 0);
        checkOutput("it3_drop_duty", duty, 132 - dbOff);
        checkOutput("it3_drop_pulses", pulses, 1);

        applyStimulus(14, 0, 82, 50, 82, 50, 0, pulses);
        checkOutput("it4_pavg", powerAvg, 4100);
        checkOutput("it4_dir", dirUp, 0);
        checkOutput("it4_duty", duty, 128 - dbOff);

        applyStimulus(20, 1, 90, 50, 90, 50, 0, pulses);
        checkOutput("sparse_pavg", powerAvg, 4500);
        checkOutput("sparse_duty", duty, 124 - dbOff);
        checkOutput("sparse_pulses", pulses, 1);

        applyStimulus(12, 1, 90, 50, 90, 50, 0, pulses);
        checkOutput("midacq_pulses", pulses, 0);
        checkOutput("midacq_busy", busy, 1);
        rst = 1'b1; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_duty", duty, 128);
        checkOutput("midrst_dir", dirUp, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pavg", powerAvg, 0);
        checkOutput("midrst_upd", dutyUpdate, 0);
        rst = 1'b0; enable = 1'b1;

        // 4000 would be a drop against the discarded 4500 if history survived reset.
        applyStimulus(15, 0, 80, 50, 80, 50, 0, pulses);
        checkOutput("postrst_pavg", powerAvg, 4000);
        checkOutput("postrst_dir", dirUp, 1);
        checkOutput("postrst_duty", duty, 132);

        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("disable_busy", busy, 0);
        checkOutput("disable_duty", duty, 132);
        enable = 1'b1;
        applyStimulus(15, 0, 60, 50, 60, 50, 0, pulses);
        checkOutput("reen_pavg", powerAvg, 3000);
        checkOutput("reen_dir", dirUp, 0);
        checkOutput("reen_duty", duty, 128);

        applyStimulus(14, 0, 100, 50, 100, 50, 0, pulses);
        checkOutput("db1_duty", duty, 124);
        applyStimulus(14, 0, 101, 50, 101, 50, 0, pulses);
        checkOutput("db2_pavg", powerAvg, 5050);
        checkOutput("db2_duty", duty, 120);
        checkOutput("db2_pulses", pulses, 1);
        applyStimulus(14, 0, 100, 50, 100, 50, 0, pulses);
        checkOutput("db3_dir", dirUp, 1);
        checkOutput("db3_duty", duty, 124);
        applyStimulus(14, 0, 100, 50, 152, 33, 0, pulses);
        checkOutput("db4_pavg", powerAvg, 5008);
        checkOutput("db4_dir", dirUp, 1);
        checkOutput("db4_duty", duty, deadbandOn ? 124 : 128);
        checkOutput("db4_pulses", pulses, deadbandOn ? 0 : 1);
        enable = 1'b0;

        enable2 = 1'b1;
        applyStimulus(15, 0, 40, 50, 40, 50, 1, pulses);
        checkOutput("clamp1_pavg", powerAvg2, 2000);
        checkOutput("clamp1_duty", duty2, 240);
        checkOutput("clamp1_dir", dirUp2, 0);
        checkOutput("clamp1_pulses", pulses, 1);
        applyStimulus(14, 0, 50, 50, 50, 50, 1, pulses);
        checkOutput("clamp2_duty", duty2, 236);
        checkOutput("clamp2_dir", dirUp2, 0);
        applyStimulus(14, 0, 20, 50, 20, 50, 1, pulses);
        checkOutput("clamp3_dir", dirUp2, 1);
        checkOutput("clamp3_duty", duty2, 240);
        applyStimulus(14, 0, 30, 50, 30, 50, 1, pulses);
        checkOutput("atmax_duty", duty2, 240);
        checkOutput("atmax_dir", dirUp2, 0);
        checkOutput("atmax_pulses", pulses, 0);
        checkOutput("idle_main_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
